// File: rtl/div_pkg.sv
// Shared types and helpers for the pipelined EX-stage divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Widest operand the helper below can describe.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient returned for a zero divisor: w ones, right-aligned.
    function automatic logic [DIV_MAX_W-1:0] div_zero_quot(input int w);
        logic [DIV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIV_MAX_W; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_sign_cond.sv
// Two-lane conditional negate. Used both to take operand magnitudes
// and to restore the signs of quotient and remainder.
module div_sign_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_a,
    input  logic             neg_b,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out
);

    // Two's-complement negate of each lane when its flag is set.
    always_comb begin
        a_out = neg_a ? -a : a;
        b_out = neg_b ? -b : b;
    end

endmodule

// File: rtl/pipe_div_unit.sv
// Iterative restoring divider for the EX stage. One quotient bit per
// cycle, MSB first; zero divisor and signed overflow finish in one cycle.
// Optional macro DIV_SMALL_BYPASS_EN: finish in one cycle when
// |divisor| > |dividend| (quotient 0, remainder = dividend).
// WIDTH is limited to div_pkg::DIV_MAX_W.
module pipe_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DZ_QUOT = WIDTH'(div_zero_quot(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] part_rem;   // partial remainder
    logic [WIDTH-1:0] shreg;      // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q, sign_r;

    // Operand conditioning
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic             div_zero, sovf, small_byp, fast, accept;
    logic [WIDTH-1:0] fast_q, fast_r;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];

    div_sign_cond #(.WIDTH(WIDTH)) u_op_cond (
        .a     (dividend),
        .b     (divisor),
        .neg_a (dvd_neg),
        .neg_b (dvs_neg),
        .a_out (dvd_abs),
        .b_out (dvs_abs)
    );

    assign div_zero = (divisor == '0);
    assign sovf     = is_signed & (dividend == MIN_NEG) & (divisor == '1);

`ifdef DIV_SMALL_BYPASS_EN
    assign small_byp = (dvs_abs > dvd_abs);
`else
    assign small_byp = 1'b0;
`endif

    assign fast   = div_zero | sovf | small_byp;
    assign accept = (state == IDLE) & start & ~flush;

    // Early-out results; zero divisor wins over the other shortcuts.
    always_comb begin
        fast_q = '0;
        fast_r = dividend;
        if (div_zero) begin
            fast_q = DZ_QUOT;
            fast_r = dividend;
        end else if (sovf) begin
            fast_q = dividend;
            fast_r = '0;
        end
    end

    // One restoring step: shift in next dividend bit, trial subtract.
    logic [WIDTH:0]   trial, diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt, sh_nxt;

    always_comb begin
        trial   = {part_rem, shreg[WIDTH-1]};
        diff    = trial - {1'b0, dvs_mag};
        qbit    = ~diff[WIDTH];
        rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        sh_nxt  = {shreg[WIDTH-2:0], qbit};
    end

    // Sign restore on the final step's raw magnitudes.
    logic [WIDTH-1:0] res_q, res_r;

    div_sign_cond #(.WIDTH(WIDTH)) u_res_cond (
        .a     (sh_nxt),
        .b     (rem_nxt),
        .neg_a (sign_q),
        .neg_b (sign_r),
        .a_out (res_q),
        .b_out (res_r)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE) & ~flush;
        stall_req = accept | (state == CALC);
        case (state)
            IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand latch, iteration, and result capture on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            part_rem  <= '0;
            shreg     <= '0;
            dvs_mag   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            part_rem <= '0;
            shreg    <= dvd_abs;
            dvs_mag  <= dvs_abs;
            sign_q   <= dvd_neg ^ dvs_neg;
            sign_r   <= dvd_neg;
            cnt      <= CNT_W'(WIDTH-1);
            if (fast) begin
                quotient  <= fast_q;
                remainder <= fast_r;
            end
        end else if ((state == CALC) && !flush) begin
            part_rem <= rem_nxt;
            shreg    <= sh_nxt;
            cnt      <= cnt - 1'b1;
            if (cnt == '0) begin
                quotient  <= res_q;
                remainder <= res_r;
            end
        end
    end

endmodule
